// File: rtl/ahb2apb_pkg_swc.sv
// rtl/ahb2apb_pkg_swc.sv - shared types and constants for the AHB-to-APB bridge
package ahb2apb_pkg_swc;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_t;

  localparam int DEF_TIMEOUT = 255;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

endpackage

// File: rtl/apb_slv_mux_swc.sv
// rtl/apb_slv_mux_swc.sv - slave-index decode to one-hot select and response mux
module apb_slv_mux_swc #(
  parameter int NSLV = 4,
  parameter int IW   = $clog2(NSLV)
) (
  input  logic [IW-1:0]      idx,
  input  logic [NSLV*32-1:0] prdata,
  input  logic [NSLV-1:0]    pready,
  input  logic [NSLV-1:0]    pslverr,
  output logic [NSLV-1:0]    sel,
  output logic [31:0]        rdata,
  output logic               ready,
  output logic               slverr
);

  always_comb begin
    sel      = '0;
    sel[idx] = 1'b1;
    rdata    = prdata[{idx, 5'd0} +: 32];
    ready    = pready[idx];
    slverr   = pslverr[idx];
  end

endmodule

// File: rtl/ahb2apb_apbm_swc.sv
// rtl/ahb2apb_apbm_swc.sv - APB master half of the AHB-to-APB bridge
module ahb2apb_apbm_swc
  import ahb2apb_pkg_swc::*;
#(
  parameter int NSLV      = 4,
  parameter int SLV_SHIFT = 12,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic               hclk,
  input  logic               hrstn,
  input  logic               wreq,
  input  logic [31:0]        wbuffdata,
  input  logic [31:0]        wbuffaddr,
  input  logic               rreq,
  input  logic [31:0]        rbuffaddr,
  output logic [31:0]        rbuffdata,
  output logic               done,
  output logic               err,
  output logic [NSLV-1:0]    psel,
  output logic               penable,
  output logic               pwrite,
  output logic [31:0]        paddr,
  output logic [31:0]        pwdata,
  input  logic [NSLV*32-1:0] prdata,
  input  logic [NSLV-1:0]    pready,
  input  logic [NSLV-1:0]    pslverr
);

  localparam int IW = $clog2(NSLV);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // Counter value during the last ACCESS cycle allowed before abort.
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  apb_state_t      state, nstate;
  logic [IW-1:0]   idx;
  logic [CW-1:0]   cnt;
  logic [NSLV-1:0] dec_sel;
  logic [31:0]     sel_rdata;
  logic            sel_ready, sel_err;
  logic            start, tmo;

  apb_slv_mux_swc #(.NSLV(NSLV), .IW(IW)) u_mux (
    .idx    (idx),
    .prdata (prdata),
    .pready (pready),
    .pslverr(pslverr),
    .sel    (dec_sel),
    .rdata  (sel_rdata),
    .ready  (sel_ready),
    .slverr (sel_err)
  );

  assign start = (state == ST_IDLE) && (wreq || rreq);
  assign tmo   = (TIMEOUT != 0) && (state == ST_ACCESS) && (cnt == CNT_LAST);

  always_ff @(posedge hclk or negedge hrstn) begin
    if (!hrstn) state <= ST_IDLE;
    else        state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      ST_IDLE:   if (wreq || rreq) nstate = ST_SETUP;
      ST_SETUP:  nstate = ST_ACCESS;
      ST_ACCESS: if (sel_ready || tmo) nstate = ST_IDLE;
      default:   nstate = ST_IDLE;
    endcase
  end

  always_comb begin
    psel    = '0;
    penable = 1'b0;
    case (state)
      ST_SETUP:  psel = dec_sel;
      ST_ACCESS: begin
        psel    = dec_sel;
        penable = 1'b1;
      end
      default: ;
    endcase
  end

  // Write wins over a simultaneous read; the read is dropped.
  always_ff @(posedge hclk or negedge hrstn) begin
    if (!hrstn) begin
      paddr  <= '0;
      pwdata <= '0;
      pwrite <= 1'b0;
      idx    <= '0;
    end else if (state == ST_IDLE) begin
      if (wreq) begin
        paddr  <= wbuffaddr;
        pwdata <= wbuffdata;
        pwrite <= 1'b1;
        idx    <= wbuffaddr[SLV_SHIFT +: IW];
      end else if (rreq) begin
        paddr  <= rbuffaddr;
        pwdata <= '0;
        pwrite <= 1'b0;
        idx    <= rbuffaddr[SLV_SHIFT +: IW];
      end
    end
  end

  always_ff @(posedge hclk or negedge hrstn) begin
    if (!hrstn)                                  cnt <= '0;
    else if (start)                              cnt <= '0;
    else if (state == ST_ACCESS && cnt != '1)    cnt <= cnt + 1'b1;
  end

  // A ready on the final allowed cycle takes precedence over the timeout.
  always_ff @(posedge hclk or negedge hrstn) begin
    if (!hrstn) begin
      done      <= 1'b0;
      err       <= 1'b0;
      rbuffdata <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (state == ST_ACCESS) begin
        if (sel_ready) begin
          done <= 1'b1;
          err  <= sel_err;
          if (!pwrite) rbuffdata <= sel_rdata;
        end else if (tmo) begin
          done <= 1'b1;
          err  <= 1'b1;
          if (!pwrite) rbuffdata <= '0;
        end
      end
    end
  end

endmodule
